// File: rtl/pcpi_issuer.sv
// PCPI initiator: accepts core-side requests, drives them onto the PCPI bus,
// and returns the coprocessor result, trap flag and measured latency.
module pcpi_issuer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_insn,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    output logic             pcpi_valid,
    output logic [31:0]      pcpi_insn,
    output logic [31:0]      pcpi_rs1,
    output logic [31:0]      pcpi_rs2,
    input  logic             pcpi_wr,
    input  logic [31:0]      pcpi_rd,
    input  logic             pcpi_wait,
    input  logic             pcpi_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_wr,
    output logic [31:0]      rsp_rd,
    output logic             rsp_trap,
    output logic [CNT_W-1:0] rsp_cycles,
    output logic             err_spurious
);

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t             state_q, state_d;
    logic               pcpi_valid_q, pcpi_valid_d;
    logic [31:0]        insn_q, insn_d;
    logic [31:0]        rs1_q, rs1_d;
    logic [31:0]        rs2_q, rs2_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_wr_q, rsp_wr_d;
    logic [31:0]        rsp_rd_q, rsp_rd_d;
    logic               rsp_trap_q, rsp_trap_d;
    logic [CNT_W-1:0]   rsp_cycles_q, rsp_cycles_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   lat_q, lat_d;
    logic [CNT_W-1:0]   to_q, to_d;
    logic [CNT_W-1:0]   to_inc;

    always_comb begin
        state_d      = state_q;
        pcpi_valid_d = pcpi_valid_q;
        insn_d       = insn_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_wr_d     = rsp_wr_q;
        rsp_rd_d     = rsp_rd_q;
        rsp_trap_d   = rsp_trap_q;
        rsp_cycles_d = rsp_cycles_q;
        lat_d        = lat_q;
        to_d         = to_q;
        to_inc       = to_q + 1'b1;
        // A ready pulse with no request on the bus is flagged and otherwise ignored
        err_d        = err_q | (pcpi_ready & ~pcpi_valid_q);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    insn_d       = req_insn;
                    rs1_d        = req_rs1;
                    rs2_d        = req_rs2;
                    pcpi_valid_d = 1'b1;
                    lat_d        = {{(CNT_W-1){1'b0}}, 1'b1};
                    to_d         = '0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                lat_d = (lat_q == '1) ? lat_q : lat_q + 1'b1;
                if (pcpi_ready) begin
                    rsp_wr_d     = pcpi_wr;
                    rsp_rd_d     = pcpi_wr ? pcpi_rd : '0;
                    rsp_trap_d   = 1'b0;
                    rsp_cycles_d = lat_q;
                    pcpi_valid_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else if (pcpi_wait) begin
                    to_d = '0;
                end else begin
                    to_d = to_inc;
                    if (to_inc == TO_LIM) begin
                        rsp_wr_d     = 1'b0;
                        rsp_rd_d     = '0;
                        rsp_trap_d   = 1'b1;
                        rsp_cycles_d = lat_q;
                        pcpi_valid_d = 1'b0;
                        rsp_valid_d  = 1'b1;
                        state_d      = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                pcpi_valid_d = 1'b0;
                rsp_valid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            pcpi_valid_q <= 1'b0;
            insn_q       <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_wr_q     <= 1'b0;
            rsp_rd_q     <= '0;
            rsp_trap_q   <= 1'b0;
            rsp_cycles_q <= '0;
            err_q        <= 1'b0;
            lat_q        <= '0;
            to_q         <= '0;
        end else begin
            state_q      <= state_d;
            pcpi_valid_q <= pcpi_valid_d;
            insn_q       <= insn_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_wr_q     <= rsp_wr_d;
            rsp_rd_q     <= rsp_rd_d;
            rsp_trap_q   <= rsp_trap_d;
            rsp_cycles_q <= rsp_cycles_d;
            err_q        <= err_d;
            lat_q        <= lat_d;
            to_q         <= to_d;
        end
    end

    // Gated by resetn so the core sees no acceptance while reset is held
    assign req_ready    = (state_q == IDLE) & resetn;
    assign pcpi_valid   = pcpi_valid_q;
    assign pcpi_insn    = insn_q;
    assign pcpi_rs1     = rs1_q;
    assign pcpi_rs2     = rs2_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_wr       = rsp_wr_q;
    assign rsp_rd       = rsp_rd_q;
    assign rsp_trap     = rsp_trap_q;
    assign rsp_cycles   = rsp_cycles_q;
    assign err_spurious = err_q;

endmodule

// File: doc/pcpi_issuer.md
Name: pcpi_issuer

Overview:
- PCPI initiator: takes custom-instruction requests from a core-side valid/ready channel and drives them onto the PCPI bus (pcpi_valid/insn/rs1/rs2).
- Waits for a coprocessor to answer (pcpi_wait/pcpi_ready) and returns result, write-enable, trap flag and measured latency on a valid/ready response channel.
- Counterpart to the team's PCPI coprocessors (e.g. DIV/REM unit); used in core integration and as a standalone coprocessor exerciser.

Parameters:
- TIMEOUT, 16, consecutive cycles with pcpi_valid high and neither pcpi_wait nor pcpi_ready seen before a trap; legal range 1..2^CNT_W-1.
- CNT_W, 16, width of latency counter and timeout counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  issuer can accept a request.
- req_insn  in  32  instruction word.
- req_rs1  in  32  operand 1.
- req_rs2  in  32  operand 2.
- pcpi_valid  out  1  PCPI request valid.
- pcpi_insn  out  32  PCPI instruction.
- pcpi_rs1  out  32  PCPI operand 1.
- pcpi_rs2  out  32  PCPI operand 2.
- pcpi_wr  in  1  coprocessor writes rd.
- pcpi_rd  in  32  coprocessor result.
- pcpi_wait  in  1  coprocessor busy, suppresses timeout.
- pcpi_ready  in  1  coprocessor done (one-cycle pulse).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_wr  out  1  captured pcpi_wr.
- rsp_rd  out  32  captured result.
- rsp_trap  out  1  no coprocessor claimed the instruction.
- rsp_cycles  out  CNT_W  cycles pcpi_valid was high for this request.
- err_spurious  out  1  sticky: pcpi_ready seen while pcpi_valid low.

Behaviour:
- Reset (async, resetn=0): state IDLE; req_ready=0 while resetn=0; pcpi_valid=0; pcpi_insn/rs1/rs2=0; rsp_valid=0; rsp_wr=0; rsp_rd=0; rsp_trap=0; rsp_cycles=0; err_spurious=0; counters cleared. Reset mid-request drops pcpi_valid immediately; the in-flight request is lost with no response.
- States:
  - IDLE
    - req_ready=1.
    - On req_valid&req_ready at edge E0: latch insn/rs1/rs2 onto pcpi_* outputs, pcpi_valid=1, lat_cnt=1, to_cnt=0, go ISSUE.
  - ISSUE
    - req_ready=0. pcpi_valid and pcpi_* held stable.
    - Each edge:
      - If pcpi_ready=1: capture rsp_wr=pcpi_wr, rsp_rd=pcpi_wr?pcpi_rd:0, rsp_trap=0, rsp_cycles=lat_cnt; pcpi_valid=0 at that same edge; rsp_valid=1; go RESP.
      - Else if pcpi_wait=1: to_cnt=0.
      - Else to_cnt+1. If that value reaches TIMEOUT: rsp_trap=1, rsp_wr=0, rsp_rd=0, rsp_cycles=lat_cnt; pcpi_valid=0; rsp_valid=1; go RESP.
    - lat_cnt increments each edge in ISSUE and saturates at all-ones.
  - RESP
    - req_ready=0; pcpi_valid=0; response fields stable.
    - On rsp_valid&rsp_ready: rsp_valid=0, go IDLE. The next request can be accepted on the following cycle; there is no same-cycle response-to-request bypass.
- Priority: pcpi_ready beats timeout on the same edge. pcpi_ready with pcpi_wait=1 is a normal completion.
- pcpi_rd is sampled only on the pcpi_ready edge. pcpi_wr=0 yields rsp_rd=0.
- err_spurious:
  - Sets when pcpi_ready=1 is sampled while pcpi_valid=0, in any state.
  - Cleared only by reset.
  - A spurious ready never generates a response.
- pcpi_wait deasserting mid-request restarts timeout counting from 0.
- Latency: pcpi_valid high the cycle after acceptance. rsp_valid high the cycle after pcpi_ready is sampled. Minimum request-to-request spacing is 3 cycles.

Test Plan:
- Bench responder pulses pcpi_ready with pcpi_wr=1, pcpi_rd=32'h0000000E on the 5th edge after pcpi_valid rises -> rsp_valid=1, rsp_rd=32'h0000000E, rsp_wr=1, rsp_trap=0, rsp_cycles=5, pcpi_valid low the same cycle rsp_valid rises.
- No responder activity, TIMEOUT=16 -> rsp_trap=1, rsp_rd=0, rsp_wr=0, rsp_cycles=16, pcpi_valid held 16 cycles.
- pcpi_wait high from cycle 3 to 39, pcpi_ready at cycle 40 with rd=32'hFFFFFFF2 -> no trap, rsp_rd=32'hFFFFFFF2, rsp_cycles=40. Also wire the team's DIV unit as responder, DIV -100/7 -> rsp_rd=32'hFFFFFFF2.
- rsp_ready=0 for 10 cycles after completion -> rsp_* stable, req_ready=0 throughout. Back-to-back req_valid is accepted only the cycle after the response handshake.
- pcpi_ready asserted on the same edge where to_cnt would reach 16 -> normal completion, rsp_trap=0. pcpi_ready pulsed in IDLE -> err_spurious=1 and stays set, no response.
- resetn asserted low mid-ISSUE (cycle 7) -> pcpi_valid=0 and rsp_valid=0 immediately, before the next clock edge. After release, a new request completes normally with rsp_cycles counted from 1.
